// File: rtl/mult_coe_pkg.sv
// mult_coe_pkg: shared state encoding and constants for the RGB gain coefficient controller
package mult_coe_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;
  localparam logic [15:0] COE_ONE = 16'h400;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
endpackage

// File: rtl/mult_coe_step.sv
// mult_coe_step: moves one gain toward its target by at most step (step 0 jumps straight there)
//   cur/tgt: current and target gain; step: per-frame bound; next: stepped gain; done: next == tgt
module mult_coe_step #(
  parameter int W = 16,
  parameter int S = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [S-1:0] step,
  output logic [W-1:0] next,
  output logic         done
);
  logic [W-1:0] d, s;
  logic         up;
  assign up = tgt >= cur;
  assign s = W'(step);
  // Distance is taken as a magnitude so the add/subtract below can never pass the target.
  assign d = up ? tgt - cur : cur - tgt;
  assign next = (step == '0 || d <= s) ? tgt : up ? cur + s : cur - s;
  assign done = next == tgt;
endmodule

// File: rtl/mult_coe_ctrl.sv
// mult_coe_ctrl: frame-synchronous shadow/target/active gain controller with optional per-frame ramp
//   wr_en_i/wr_addr_i/wr_data_i: shadow write; commit_i: shadow -> target, arm; step_i: ramp step
//   vs_i: vertical sync; coe_o: active gains packed per channel; busy_o: update pending or ramping
//   update_o: pulses in the cycle coe_o shows a new value
module mult_coe_ctrl
  import mult_coe_pkg::*;
#(
  parameter int                   COE_WIDTH   = 16,
  parameter int                   COE_COUNT   = 3,
  parameter logic [COE_WIDTH-1:0] COE_DEFAULT = COE_WIDTH'(COE_ONE),
  parameter int                   STEP_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en_i,
  input  logic [1:0]                     wr_addr_i,
  input  logic [COE_WIDTH-1:0]           wr_data_i,
  input  logic                           commit_i,
  input  logic [STEP_WIDTH-1:0]          step_i,
  input  logic                           vs_i,
  output logic [COE_WIDTH*COE_COUNT-1:0] coe_o,
  output logic                           busy_o,
  output logic                           update_o
);
  localparam int W = COE_WIDTH;
  localparam int N = COE_COUNT;
  logic [W-1:0]          shadow [N];
  logic [W-1:0]          shadow_nx [N];
  logic [W-1:0]          target [N];
  logic [W-1:0]          coe [N];
  logic [W-1:0]          nxt [N];
  logic [N-1:0]          done, chg;
  logic [STEP_WIDTH-1:0] step_q;
  logic                  vs_q, fe, apply;
  state_t                state, state_nx;
  assign fe = vs_i & ~vs_q;
  assign apply = fe && state != IDLE;
  for (genvar i = 0; i < N; i++) begin : g_ch
    // Write-through: a commit in the same cycle as a write latches the written value.
    assign shadow_nx[i] = (wr_en_i && wr_addr_i == 2'(i)) ? wr_data_i : shadow[i];
    mult_coe_step #(.W(W), .S(STEP_WIDTH)) u_step (
      .cur(coe[i]), .tgt(target[i]), .step(step_q), .next(nxt[i]), .done(done[i])
    );
    assign chg[i] = nxt[i] != coe[i];
    assign coe_o[i*W +: W] = coe[i];
  end
  // A commit always re-arms, even when it coincides with a frame edge stepping toward the old target.
  always_comb begin
    state_nx = state;
    if (apply) state_nx = &done ? IDLE : RAMP;
    if (commit_i) state_nx = ARMED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy_o <= 1'b0;
    end else begin
      state <= state_nx;
      busy_o <= state_nx != IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        shadow[k] <= COE_DEFAULT;
        target[k] <= COE_DEFAULT;
        coe[k] <= COE_DEFAULT;
      end
      step_q <= '0;
      vs_q <= 1'b0;
      update_o <= 1'b0;
    end else begin
      vs_q <= vs_i;
      update_o <= apply && |chg;
      if (commit_i) step_q <= step_i;
      for (int k = 0; k < N; k++) begin
        shadow[k] <= shadow_nx[k];
        if (commit_i) target[k] <= shadow_nx[k];
        if (apply) coe[k] <= nxt[k];
      end
    end
  end
endmodule

// File: tb/tb_mult_coe_ctrl.sv
// tb_mult_coe_ctrl: directed stimulus, per-cycle behavioural model compare plus literal expectations
module tb_mult_coe_ctrl;
  import mult_coe_pkg::*;
  logic        clk = 0, rst_n = 0, wr_en = 0, commit = 0, vs = 0;
  logic [1:0]  wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [7:0]  step = 0;
  logic [47:0] coe;
  logic        busy, update, upd_seen;
  int          vectors = 0, errors = 0;
  bit          valid = 0;
  int          m_sh[3], m_tg[3], m_coe[3], m_step;
  bit          m_busy, m_upd, m_vsq;

  mult_coe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .commit_i(commit), .step_i(step), .vs_i(vs), .coe_o(coe), .busy_o(busy), .update_o(update)
  );

  always #5 clk = ~clk;

  function automatic int toward(int c, int t, int s);
    if (s == 0 || (t > c ? t - c : c - t) <= s) return t;
    return t > c ? c + s : c - s;
  endfunction

  always @(posedge clk) begin : model
    int sh[3];
    int n;
    bit fe, all_done;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_sh[k] = 'h400; m_tg[k] = 'h400; m_coe[k] = 'h400;
      end
      m_step = 0; m_busy = 0; m_upd = 0; m_vsq = 0; valid = 1;
    end else begin
      fe = vs && !m_vsq;
      sh = m_sh;
      if (wr_en && wr_addr < 3) sh[wr_addr] = int'(wr_data);
      m_upd = 0;
      if (fe && m_busy) begin
        all_done = 1;
        for (int k = 0; k < 3; k++) begin
          n = toward(m_coe[k], m_tg[k], m_step);
          if (n != m_coe[k]) m_upd = 1;
          if (n != m_tg[k]) all_done = 0;
          m_coe[k] = n;
        end
        m_busy = !all_done;
      end
      if (commit) begin
        m_tg = sh; m_step = int'(step); m_busy = 1;
      end
      m_sh = sh;
      m_vsq = vs;
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (valid) begin
    chk("model_coe", coe, {m_coe[2][15:0], m_coe[1][15:0], m_coe[0][15:0]});
    chk("model_busy", 48'(busy), 48'(m_busy));
    chk("model_update", 48'(update), 48'(m_upd));
  end

  task automatic lit(input string n, input logic [15:0] r, g, b, input logic bz);
    chk(n, coe, {b, g, r});
    chk({n, "_busy"}, 48'(busy), 48'(bz));
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic cmt(input logic [7:0] s);
    commit = 1; step = s;
    @(negedge clk);
    commit = 0;
  endtask

  task automatic frame;
    vs = 1;
    @(negedge clk);
    upd_seen = update;
    @(negedge clk);
    vs = 0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk); vs = 1;
    @(negedge clk); vs = 0;
    rst_n = 1;
    lit("reset", 'h400, 'h400, 'h400, 0);
    chk("reset_update", 48'(update), 48'(0));
    frame;
    lit("idle_frame", 'h400, 'h400, 'h400, 0);
    chk("idle_frame_update", 48'(upd_seen), 48'(0));

    wr(CH_R, 'h200); wr(CH_G, 'h400); wr(CH_B, 'h800); cmt(0);
    repeat (2) @(negedge clk);
    lit("jump_wait", 'h400, 'h400, 'h400, 1);
    frame;
    lit("jump", 'h200, 'h400, 'h800, 0);
    chk("jump_update", 48'(upd_seen), 48'(1));

    wr(CH_R, 'h400); wr(CH_B, 'h400); cmt(0); frame;
    lit("ramp_base", 'h400, 'h400, 'h400, 0);
    wr(CH_R, 'h500); cmt('h40);
    frame; lit("ramp1", 'h440, 'h400, 'h400, 1);
    frame; lit("ramp2", 'h480, 'h400, 'h400, 1);
    frame; lit("ramp3", 'h4C0, 'h400, 'h400, 1);
    frame; lit("ramp4", 'h500, 'h400, 'h400, 0);
    wr(CH_R, 'h4F0); cmt('h40); frame;
    lit("ramp_down", 'h4F0, 'h400, 'h400, 0);

    wr(CH_R, 'h400); cmt(0); frame;
    wr(CH_R, 'h500); cmt('h40);
    frame; frame;
    lit("retarget_pre", 'h480, 'h400, 'h400, 1);
    wr(CH_R, 'h400); cmt('h40);
    frame; lit("retarget1", 'h440, 'h400, 'h400, 1);
    frame; lit("retarget2", 'h400, 'h400, 'h400, 0);

    wr_en = 1; wr_addr = CH_G; wr_data = 'h300; commit = 1; step = 0;
    @(negedge clk);
    wr_en = 0; commit = 0;
    lit("wr_commit_wait", 'h400, 'h400, 'h400, 1);
    frame; lit("wr_commit", 'h400, 'h300, 'h400, 0);
    wr(CH_R, 'h500); cmt('h40); frame;
    lit("fe_commit_pre", 'h440, 'h300, 'h400, 1);
    wr(CH_R, 'h600);
    vs = 1; commit = 1; step = 'h40;
    @(negedge clk);
    commit = 0;
    lit("fe_commit", 'h480, 'h300, 'h400, 1);
    @(negedge clk); vs = 0; @(negedge clk);
    frame; lit("fe_commit_next", 'h4C0, 'h300, 'h400, 1);
    wr(2'd3, 'h123); cmt(0); frame;
    lit("addr3_ignored", 'h600, 'h300, 'h400, 0);

    wr(CH_R, 'h400); cmt('h10); frame;
    lit("rst_ramp_pre", 'h5F0, 'h300, 'h400, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    lit("rst_ramp", 'h400, 'h400, 'h400, 0);
    frame; lit("rst_ramp_fe", 'h400, 'h400, 'h400, 0);

    vs = 1;
    repeat (2) @(negedge clk);
    wr(CH_R, 'h500); cmt(0);
    repeat (3) @(negedge clk);
    lit("vs_held", 'h400, 'h400, 'h400, 1);
    vs = 0;
    @(negedge clk);
    frame; lit("vs_held_edge", 'h500, 'h400, 'h400, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
